// File: rtl/ioff_ctrl_pkg.sv
// Shared types and defaults for the IOFF scan-chain load sequencer.
package ioff_ctrl_pkg;

  localparam int DEF_CHAIN_LEN     = 16;
  localparam int DEF_SETTLE_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    VERIFY,
    SETTLE,
    DONE
  } state_t;

endpackage

// File: rtl/ioff_chain_ctrl.sv
// Serially loads a configuration word into an IOFF scan chain, captures the old contents, then applies mode select.
// Define IOFF_READBACK_EN to add a VERIFY pass that re-shifts the word and flags mismatches on rb_err.
module ioff_chain_ctrl
  import ioff_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN     = DEF_CHAIN_LEN,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  localparam int CNT_W        = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 CK,
  input  logic                 global_reset,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] cfg_data,
  input  logic                 mode_sel_cfg,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] old_data,
  output logic                 ioff_si,
  output logic                 ioff_se,
  output logic                 ioff_mode_sel,
  input  logic                 ioff_so,
  output logic                 rb_err
);

  localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_SETTLE = CNT_W'(SETTLE_CYCLES - 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [CHAIN_LEN-1:0] shadow;
  logic                 shadow_mode;

  // shadow rotates one place per shift so bit 0 is always the current bit and
  // bit 1 the next; after a full pass it is back to the captured word.
  always_ff @(posedge CK) begin
    if (global_reset) begin
      state         <= IDLE;
      cnt           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      ioff_si       <= 1'b0;
      ioff_se       <= 1'b0;
      ioff_mode_sel <= 1'b0;
      rb_err        <= 1'b0;
      old_data      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shadow      <= cfg_data;
            shadow_mode <= mode_sel_cfg;
            old_data    <= '0;
            rb_err      <= 1'b0;
            cnt         <= '0;
            busy        <= 1'b1;
            ioff_se     <= 1'b1;
            ioff_si     <= cfg_data[0];
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          old_data <= {ioff_so, old_data[CHAIN_LEN-1:1]};
          shadow   <= {shadow[0], shadow[CHAIN_LEN-1:1]};
          if (cnt == LAST_BIT) begin
            cnt <= '0;
`ifdef IOFF_READBACK_EN
            ioff_si <= shadow[1];
            state   <= VERIFY;
`else
            ioff_se <= 1'b0;
            ioff_si <= 1'b0;
            state   <= SETTLE;
`endif
          end else begin
            cnt     <= cnt + 1'b1;
            ioff_si <= shadow[1];
          end
        end
        VERIFY: begin
`ifdef IOFF_READBACK_EN
          shadow <= {shadow[0], shadow[CHAIN_LEN-1:1]};
          if (ioff_so != shadow[0]) rb_err <= 1'b1;
          if (cnt == LAST_BIT) begin
            cnt     <= '0;
            ioff_se <= 1'b0;
            ioff_si <= 1'b0;
            state   <= SETTLE;
          end else begin
            cnt     <= cnt + 1'b1;
            ioff_si <= shadow[1];
          end
`else
          state <= IDLE;
`endif
        end
        SETTLE: begin
          if (cnt == LAST_SETTLE) begin
            cnt           <= '0;
            done          <= 1'b1;
            ioff_mode_sel <= shadow_mode;
            state         <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ioff_chain_ctrl.sv
// Directed bench for ioff_chain_ctrl with a behavioural IOFF chain model; readback tests need IOFF_READBACK_EN.
module tb_ioff_chain_ctrl;

  localparam int LEN    = 16;
  localparam int SETTLE = 2;
`ifdef IOFF_READBACK_EN
  localparam int LAT    = 1 + 2 * LEN + SETTLE;
  localparam int SE_EXP = 2 * LEN;
`else
  localparam int LAT    = 1 + LEN + SETTLE;
  localparam int SE_EXP = LEN;
`endif

  logic            CK = 1'b0;
  logic            global_reset = 1'b1;
  logic            start = 1'b0;
  logic [LEN-1:0]  cfg_data = '0;
  logic            mode_sel_cfg = 1'b0;
  logic            busy, done, ioff_si, ioff_se, ioff_mode_sel, ioff_so, rb_err;
  logic [LEN-1:0]  old_data;

  logic [LEN-1:0]  chain = '0;
  logic [LEN-1:0]  pre_val = '0;
  logic            pre_en = 1'b0;
  logic            stuck5 = 1'b0;

  int errors = 0;
  int checks = 0;

  ioff_chain_ctrl #(.CHAIN_LEN(LEN), .SETTLE_CYCLES(SETTLE)) dut (
    .CK(CK), .global_reset(global_reset), .start(start), .cfg_data(cfg_data),
    .mode_sel_cfg(mode_sel_cfg), .busy(busy), .done(done), .old_data(old_data),
    .ioff_si(ioff_si), .ioff_se(ioff_se), .ioff_mode_sel(ioff_mode_sel),
    .ioff_so(ioff_so), .rb_err(rb_err)
  );

  always #5 CK = ~CK;

  // Chain model: SI enters at the head (MSB side), SO is the tail bit 0.
  assign ioff_so = chain[0];
  always @(posedge CK) begin
    if (pre_en) chain <= pre_val;
    else if (ioff_se) chain <= stuck5 ? ({ioff_si, chain[LEN-1:1]} & ~16'h0020)
                                      : {ioff_si, chain[LEN-1:1]};
  end

  task automatic preload(input logic [LEN-1:0] v);
    @(negedge CK); pre_val = v; pre_en = 1'b1;
    @(negedge CK); pre_en = 1'b0;
  endtask

  task automatic do_load(input logic [LEN-1:0] cfg, input logic mode,
                         output int dcyc, output logic [LEN-1:0] siw,
                         output int sec, output int sef, output int sel,
                         output logic mode_c1);
    dcyc = -1; siw = '0; sec = 0; sef = -1; sel = -1; mode_c1 = 1'bx;
    @(negedge CK); cfg_data = cfg; mode_sel_cfg = mode; start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge CK); start = 1'b0;
      if (c == 1) mode_c1 = ioff_mode_sel;
      if (ioff_se) begin
        if (sec < LEN) siw[sec] = ioff_si;
        sec++;
        if (sef < 0) sef = c;
        sel = c;
      end
      if (done) begin dcyc = c; break; end
    end
  endtask

  task automatic test_reset;
    global_reset = 1'b1;
    repeat (3) @(negedge CK);
    global_reset = 1'b0;
    @(negedge CK);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (ioff_se !== 1'b0) begin errors++; $display("FAIL reset_se got=%b want=0", ioff_se); end
    checks++; if (ioff_si !== 1'b0) begin errors++; $display("FAIL reset_si got=%b want=0", ioff_si); end
    checks++; if (ioff_mode_sel !== 1'b0) begin errors++; $display("FAIL reset_mode got=%b want=0", ioff_mode_sel); end
    checks++; if (rb_err !== 1'b0) begin errors++; $display("FAIL reset_rberr got=%b want=0", rb_err); end
    checks++; if (old_data !== 16'h0000) begin errors++; $display("FAIL reset_old got=%h want=0000", old_data); end
  endtask

  task automatic test_load;
    int dcyc, sec, sef, sel;
    logic [LEN-1:0] siw;
    logic mc1;
    preload(16'h1234);
    do_load(16'hA5C3, 1'b1, dcyc, siw, sec, sef, sel, mc1);
    checks++; if (dcyc !== LAT) begin errors++; $display("FAIL load_latency got=%0d want=%0d", dcyc, LAT); end
    checks++; if (sef !== 1) begin errors++; $display("FAIL load_first_se got=%0d want=1", sef); end
    checks++; if (sec !== SE_EXP) begin errors++; $display("FAIL load_se_count got=%0d want=%0d", sec, SE_EXP); end
    checks++; if (sel - sef + 1 !== sec) begin errors++; $display("FAIL load_se_contig span=%0d count=%0d", sel - sef + 1, sec); end
    checks++; if (siw !== 16'hA5C3) begin errors++; $display("FAIL load_si_seq got=%h want=a5c3", siw); end
    checks++; if (mc1 !== 1'b0) begin errors++; $display("FAIL load_mode_early got=%b want=0", mc1); end
    checks++; if (old_data !== 16'h1234) begin errors++; $display("FAIL load_old got=%h want=1234", old_data); end
    checks++; if (chain !== 16'hA5C3) begin errors++; $display("FAIL load_chain got=%h want=a5c3", chain); end
    checks++; if (ioff_mode_sel !== 1'b1) begin errors++; $display("FAIL load_mode got=%b want=1", ioff_mode_sel); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy_at_done got=%b want=1", busy); end
    checks++; if (rb_err !== 1'b0) begin errors++; $display("FAIL load_rberr got=%b want=0", rb_err); end
    @(negedge CK);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load_busy_after got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL load_done_width got=%b want=0", done); end
    checks++; if (old_data !== 16'h1234) begin errors++; $display("FAIL load_old_held got=%h want=1234", old_data); end
  endtask

  task automatic test_start_held;
    int dn = 0;
    int d2 = -1;
    logic b1, b2, se2;
    @(negedge CK); cfg_data = 16'h3C5A; mode_sel_cfg = 1'b1; start = 1'b1;
    for (int c = 1; c <= LAT + 1; c++) begin
      @(negedge CK);
      if (done) dn++;
      if (c == LAT + 1) b1 = busy;
    end
    @(negedge CK);
    b2 = busy; se2 = ioff_se; start = 1'b0;
    for (int c = LAT + 2; c <= LAT + 100; c++) begin
      if (done) begin d2 = c; break; end
      @(negedge CK);
    end
    checks++; if (dn !== 1) begin errors++; $display("FAIL held_done_count got=%0d want=1", dn); end
    checks++; if (b1 !== 1'b0) begin errors++; $display("FAIL held_busy_idle got=%b want=0", b1); end
    checks++; if (b2 !== 1'b1) begin errors++; $display("FAIL held_busy_reload got=%b want=1", b2); end
    checks++; if (se2 !== 1'b1) begin errors++; $display("FAIL held_se_reload got=%b want=1", se2); end
    checks++; if (d2 !== 2 * LAT + 1) begin errors++; $display("FAIL held_done2 got=%0d want=%0d", d2, 2 * LAT + 1); end
    checks++; if (chain !== 16'h3C5A) begin errors++; $display("FAIL held_chain got=%h want=3c5a", chain); end
    @(negedge CK);
  endtask

  task automatic test_reset_mid;
    int dn = 0;
    int dcyc, sec, sef, sel;
    logic [LEN-1:0] siw, snap;
    logic mc1;
    @(negedge CK); cfg_data = 16'hFFFF; mode_sel_cfg = 1'b1; start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CK); start = 1'b0;
    end
    checks++; if (ioff_se !== 1'b1) begin errors++; $display("FAIL mid_se_shift got=%b want=1", ioff_se); end
    global_reset = 1'b1;
    @(negedge CK);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b want=0", busy); end
    checks++; if (ioff_se !== 1'b0) begin errors++; $display("FAIL mid_se got=%b want=0", ioff_se); end
    checks++; if (ioff_mode_sel !== 1'b0) begin errors++; $display("FAIL mid_mode got=%b want=0", ioff_mode_sel); end
    checks++; if (old_data !== 16'h0000) begin errors++; $display("FAIL mid_old got=%h want=0000", old_data); end
    global_reset = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge CK);
      if (done) dn++;
    end
    checks++; if (dn !== 0) begin errors++; $display("FAIL mid_no_done got=%0d want=0", dn); end
    snap = chain;
    do_load(16'h0F0F, 1'b0, dcyc, siw, sec, sef, sel, mc1);
    checks++; if (dcyc !== LAT) begin errors++; $display("FAIL mid_fresh_latency got=%0d want=%0d", dcyc, LAT); end
    checks++; if (old_data !== snap) begin errors++; $display("FAIL mid_fresh_old got=%h want=%h", old_data, snap); end
    checks++; if (chain !== 16'h0F0F) begin errors++; $display("FAIL mid_fresh_chain got=%h want=0f0f", chain); end
    checks++; if (ioff_mode_sel !== 1'b0) begin errors++; $display("FAIL mid_fresh_mode got=%b want=0", ioff_mode_sel); end
    @(negedge CK);
  endtask

`ifdef IOFF_READBACK_EN
  task automatic test_readback;
    int dcyc, sec, sef, sel;
    int d3 = -1;
    logic [LEN-1:0] siw;
    logic mc1;
    preload(16'h0000);
    do_load(16'hFFFF, 1'b1, dcyc, siw, sec, sef, sel, mc1);
    checks++; if (dcyc !== 35) begin errors++; $display("FAIL rb_good_latency got=%0d want=35", dcyc); end
    checks++; if (rb_err !== 1'b0) begin errors++; $display("FAIL rb_good_err got=%b want=0", rb_err); end
    checks++; if (chain !== 16'hFFFF) begin errors++; $display("FAIL rb_good_chain got=%h want=ffff", chain); end
    stuck5 = 1'b1;
    do_load(16'hFFFF, 1'b0, dcyc, siw, sec, sef, sel, mc1);
    checks++; if (dcyc !== 35) begin errors++; $display("FAIL rb_bad_latency got=%0d want=35", dcyc); end
    checks++; if (rb_err !== 1'b1) begin errors++; $display("FAIL rb_bad_err got=%b want=1", rb_err); end
    checks++; if (chain !== 16'hFFDF) begin errors++; $display("FAIL rb_bad_chain got=%h want=ffdf", chain); end
    @(negedge CK);
    checks++; if (rb_err !== 1'b1) begin errors++; $display("FAIL rb_bad_sticky got=%b want=1", rb_err); end
    stuck5 = 1'b0;
    cfg_data = 16'hFFFF; start = 1'b1;
    @(negedge CK); start = 1'b0;
    checks++; if (rb_err !== 1'b0) begin errors++; $display("FAIL rb_clear got=%b want=0", rb_err); end
    for (int c = 2; c <= 100; c++) begin
      @(negedge CK);
      if (done) begin d3 = c; break; end
    end
    checks++; if (d3 !== 35) begin errors++; $display("FAIL rb_reload_latency got=%0d want=35", d3); end
    checks++; if (rb_err !== 1'b0) begin errors++; $display("FAIL rb_reload_err got=%b want=0", rb_err); end
    @(negedge CK);
  endtask
`endif

  initial begin
    test_reset;
    test_load;
    test_start_held;
    test_reset_mid;
`ifdef IOFF_READBACK_EN
    test_readback;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
